// File: rtl/lane_flag_reader.sv
// Edge-detects per-lane flag inputs, keeps one sticky pending bit per lane and emits
// pending lane indices round-robin on a valid/ready stream, counting dropped events.
module lane_flag_reader #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = $clog2(NUM_LANES),
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] lane_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic [NUM_LANES-1:0] overflow,
    output logic [CNT_W-1:0]     drop_cnt,
    input  logic                 clr_drop
);

    // Handshake: a word transfers on a rising edge where out_valid & out_ready; while
    // out_valid=1 and out_ready=0, out_idx is held stable until accepted.

    localparam int DSUM_W = CNT_W + 6;
    localparam logic [DSUM_W-1:0] CNT_MAX = {{6{1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_LANES-1:0] prev_flag;
    logic [NUM_LANES-1:0] pending;
    logic [IDX_W-1:0]     rr_ptr;

    logic [NUM_LANES-1:0] rise;
    logic                 load_en;
    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     rr_next;
    logic [NUM_LANES-1:0] load_mask;
    logic [NUM_LANES-1:0] drop;
    logic [NUM_LANES-1:0] pending_next;
    logic [DSUM_W-1:0]    drop_sum;
    logic [DSUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]     cnt_next;

    assign rise    = lane_flag & ~prev_flag;
    assign load_en = ~out_valid | out_ready;

    // Round-robin search over the registered pending vector, starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_LANES);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        rr_next = (int'(sel) == NUM_LANES - 1) ? '0 : sel + 1'b1;
    end

    // A lane loaded on the same edge as its rise stays pending; otherwise a repeat rise drops.
    always_comb begin
        load_mask    = '0;
        drop         = '0;
        pending_next = pending;
        drop_sum     = '0;
        if (load_en && found) begin
            load_mask[sel] = 1'b1;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (load_mask[i]) begin
                pending_next[i] = rise[i];
            end else if (rise[i]) begin
                drop[i]         = pending[i];
                pending_next[i] = 1'b1;
            end
            drop_sum = drop_sum + DSUM_W'(drop[i]);
        end
        cnt_sum  = DSUM_W'(drop_cnt) + drop_sum;
        cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_flag <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            rr_ptr    <= '0;
            overflow  <= '0;
            drop_cnt  <= '0;
        end else begin
            prev_flag <= lane_flag;
            pending   <= pending_next;
            if (load_en) begin
                if (found) begin
                    out_valid <= 1'b1;
                    out_idx   <= sel;
                    rr_ptr    <= rr_next;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            // Clear has priority over a drop on the same edge.
            if (clr_drop) begin
                overflow <= '0;
                drop_cnt <= '0;
            end else begin
                overflow <= overflow | drop;
                drop_cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_lane_flag_reader.sv
// Directed bench for lane_flag_reader (4 lanes, 8-bit drop counter) with hand-computed
// expectations checked by immediate assertions.
module tb_lane_flag_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lane_flag;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic [3:0] overflow;
    logic [7:0] drop_cnt;
    logic       clr_drop;

    int n_vec = 0;
    int n_err = 0;

    lane_flag_reader #(.NUM_LANES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lane_flag (lane_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_drop  (clr_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    endtask

    initial begin
        rst_n     = 1'b0;
        lane_flag = 4'b0000;
        out_ready = 1'b1;
        clr_drop  = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;

        // Idle
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
        chk("idle_cnt", 32'(drop_cnt), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);

        // Single lane 2, held high: emitted once, one edge after pending sets
        lane_flag = 4'b0100;
        tick();
        chk_out("l2_pend", 1'b0, 2'd0);
        tick();
        chk_out("l2_emit", 1'b1, 2'd2);
        tick();
        chk_out("l2_done", 1'b0, 2'd0);
        repeat (3) begin
            tick();
            chk_out("l2_held", 1'b0, 2'd0);
        end
        lane_flag = 4'b0000;
        tick();

        // Lane 3 alone moves rr_ptr back to 0
        lane_flag = 4'b1000;
        tick();
        lane_flag = 4'b0000;
        tick();
        chk_out("l3_emit", 1'b1, 2'd3);
        tick();
        chk_out("l3_done", 1'b0, 2'd0);

        // All four lanes together: 0,1,2,3 back to back
        lane_flag = 4'b1111;
        tick();
        lane_flag = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("all_seq", 1'b1, 2'(i));
        end
        tick();
        chk_out("all_done", 1'b0, 2'd0);

        // Lane 2 alone leaves rr_ptr=3, then lanes {0,3}: wrap gives 3 then 0
        lane_flag = 4'b0100;
        tick();
        lane_flag = 4'b0000;
        tick();
        chk_out("wr_l2", 1'b1, 2'd2);
        tick();
        lane_flag = 4'b1001;
        tick();
        lane_flag = 4'b0000;
        tick();
        chk_out("wrap_a", 1'b1, 2'd3);
        tick();
        chk_out("wrap_b", 1'b1, 2'd0);
        tick();
        chk_out("wrap_done", 1'b0, 2'd0);

        // Stall with idx 1 held; lane 1 pulses twice during the stall
        lane_flag = 4'b0010;
        tick();
        lane_flag = 4'b0000;
        out_ready = 1'b0;
        tick();
        chk_out("st_load", 1'b1, 2'd1);
        lane_flag = 4'b0010;
        tick();
        chk_out("st_c1", 1'b1, 2'd1);
        chk("st_nodrop_cnt", 32'(drop_cnt), 32'd0);
        chk("st_nodrop_ovf", 32'(overflow), 32'd0);
        lane_flag = 4'b0000;
        tick();
        chk_out("st_c2", 1'b1, 2'd1);
        lane_flag = 4'b0010;
        tick();
        chk_out("st_c3", 1'b1, 2'd1);
        chk("st_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("st_drop_ovf", 32'(overflow), 32'b0010);
        lane_flag = 4'b0000;
        tick();
        chk_out("st_c4", 1'b1, 2'd1);
        tick();
        chk_out("st_c5", 1'b1, 2'd1);
        // Release the stall with a rise on lane 1 as it is loaded: stays pending, no drop
        out_ready = 1'b1;
        lane_flag = 4'b0010;
        tick();
        chk_out("st_rel", 1'b1, 2'd1);
        chk("st_rel_cnt", 32'(drop_cnt), 32'd1);
        lane_flag = 4'b0000;
        tick();
        chk_out("st_again", 1'b1, 2'd1);
        chk("st_again_cnt", 32'(drop_cnt), 32'd1);
        tick();
        chk_out("st_done", 1'b0, 2'd0);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Lane 0 toggling under a full stall saturates the counter
        out_ready = 1'b0;
        for (int i = 0; i < 600; i++) begin
            lane_flag = {3'b000, ~lane_flag[0]};
            tick();
        end
        chk("sat_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'b0001);
        chk_out("sat_out", 1'b1, 2'd0);
        lane_flag = 4'b0001;
        clr_drop  = 1'b1;
        tick();
        clr_drop  = 1'b0;
        lane_flag = 4'b0000;
        chk("clrwin_cnt", 32'(drop_cnt), 32'd0);
        chk("clrwin_ovf", 32'(overflow), 32'd0);
        tick();
        chk("clr_hold_cnt", 32'(drop_cnt), 32'd0);

        // Asynchronous reset mid-cycle while a word is held
        chk_out("pre_rst", 1'b1, 2'd0);
        rst_n     = 1'b0;
        lane_flag = 4'b1000;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        tick();
        chk("arst_hold", 32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_out("rel_e1", 1'b0, 2'd0);
        tick();
        chk_out("rel_e2", 1'b1, 2'd3);
        tick();
        chk_out("rel_e3", 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
